// File: rtl/skin_classifier_stream.sv
// Streaming YCbCr skin classifier: 2-stage valid/ready pipeline, per-profile thresholds
// committed at start-of-frame, and a saturating per-frame skin pixel counter.
module skin_classifier_stream #(
    parameter int DATA_W = 8,
    parameter int N_PROF = 4,
    parameter int PROF_W = 2,
    parameter int CNT_W  = 20,
    parameter int Y_MIN  = 80,
    parameter int Y_MAX  = 235,
    parameter int CB_MIN = 85,
    parameter int CB_MAX = 135,
    parameter int CR_MIN = 135,
    parameter int CR_MAX = 180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_cb,
    input  logic [DATA_W-1:0] in_cr,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [PROF_W-1:0] prof_sel,
    input  logic              cfg_we,
    input  logic [PROF_W+2:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mask,
    output logic              out_sof,
    output logic              out_eof,
    output logic              stat_valid,
    output logic [CNT_W-1:0]  stat_count,
    output logic [PROF_W-1:0] stat_prof
);
    localparam int N_FLD = 6;

    logic [DATA_W-1:0] shadow  [N_PROF][N_FLD];
    logic [DATA_W-1:0] act_thr [N_FLD];
    logic [DATA_W-1:0] sel_thr [N_FLD];
    logic [DATA_W-1:0] use_thr [N_FLD];
    logic [PROF_W-1:0] act_prof, use_prof, s1_prof, out_prof;
    logic [PROF_W-1:0] cfg_prof;
    logic [2:0]        cfg_fld;
    logic              adv, sof_acc, s1_valid, s1_sof, s1_eof;
    logic [5:0]        cmp, s1_cmp;
    logic [CNT_W-1:0]  cnt, total;

    function automatic logic [DATA_W-1:0] thr_default(input int f);
        case (f)
            0:       return DATA_W'(Y_MIN);
            1:       return DATA_W'(Y_MAX);
            2:       return DATA_W'(CB_MIN);
            3:       return DATA_W'(CB_MAX);
            4:       return DATA_W'(CR_MIN);
            default: return DATA_W'(CR_MAX);
        endcase
    endfunction

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv & rst_n;
    assign sof_acc  = in_valid & in_ready & in_sof;
    assign cfg_prof = cfg_addr[PROF_W+2:3];
    assign cfg_fld  = cfg_addr[2:0];

    // The SOF pixel must see the freshly committed bank, including a same-cycle write.
    always_comb begin
        for (int f = 0; f < N_FLD; f++) begin
            sel_thr[f] = shadow[prof_sel][f];
            if (cfg_we && cfg_prof == prof_sel && cfg_fld == 3'(f))
                sel_thr[f] = cfg_wdata;
            use_thr[f] = sof_acc ? sel_thr[f] : act_thr[f];
        end
        use_prof = sof_acc ? prof_sel : act_prof;
    end

    assign cmp[0] = in_y  >= use_thr[0];
    assign cmp[1] = in_y  <= use_thr[1];
    assign cmp[2] = in_cb >= use_thr[2];
    assign cmp[3] = in_cb <= use_thr[3];
    assign cmp[4] = in_cr >= use_thr[4];
    assign cmp[5] = in_cr <= use_thr[5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < N_PROF; p++)
                for (int f = 0; f < N_FLD; f++)
                    shadow[p][f] <= thr_default(f);
            for (int f = 0; f < N_FLD; f++)
                act_thr[f] <= thr_default(f);
            act_prof <= '0;
        end else begin
            for (int f = 0; f < N_FLD; f++)
                if (cfg_we && cfg_fld == 3'(f))
                    shadow[cfg_prof][f] <= cfg_wdata;
            if (sof_acc) begin
                for (int f = 0; f < N_FLD; f++)
                    act_thr[f] <= sel_thr[f];
                act_prof <= prof_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eof    <= 1'b0;
            s1_cmp    <= '0;
            s1_prof   <= '0;
            out_valid <= 1'b0;
            out_mask  <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_prof  <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_sof    <= in_valid & in_sof;
            s1_eof    <= in_valid & in_eof;
            s1_cmp    <= in_valid ? cmp : '0;
            s1_prof   <= use_prof;
            out_valid <= s1_valid;
            out_mask  <= s1_valid & (&s1_cmp);
            out_sof   <= s1_sof;
            out_eof   <= s1_eof;
            out_prof  <= s1_prof;
        end
    end

    always_comb begin
        total = cnt;
        if (out_sof)
            total = CNT_W'(out_mask);
        else if (cnt != '1)
            total = cnt + CNT_W'(out_mask);
    end

    // Counter clears after EOF so a frame missing its SOF still reports its own pixels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            stat_valid <= 1'b0;
            stat_count <= '0;
            stat_prof  <= '0;
        end else begin
            stat_valid <= 1'b0;
            if (out_valid && out_ready) begin
                cnt <= out_eof ? '0 : total;
                if (out_eof) begin
                    stat_valid <= 1'b1;
                    stat_count <= total;
                    stat_prof  <= out_prof;
                end
            end
        end
    end
endmodule

// File: tb/tb_skin_classifier_stream.sv
// Bench for skin_classifier_stream: vector table plus scoreboard, with a CNT_W=3 twin for saturation.
module tb_skin_classifier_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_y = '0, in_cb = '0, in_cr = '0;
    logic        in_sof = 1'b0, in_eof = 1'b0;
    logic [1:0]  prof_sel = '0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [7:0]  cfg_wdata = '0;
    logic        out_ready;
    logic        rdy_force = 1'b1, rand_rdy = 1'b0, rnd_bit = 1'b1;
    logic        in_ready, out_valid, out_mask, out_sof, out_eof, stat_valid;
    logic [19:0] stat_count;
    logic [1:0]  stat_prof;
    logic        in_ready2, out_valid2, out_mask2, out_sof2, out_eof2, stat_valid2;
    logic [2:0]  stat_count2;
    logic [1:0]  stat_prof2;

    assign out_ready = rand_rdy ? rnd_bit : rdy_force;

    skin_classifier_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_sof(in_sof), .in_eof(in_eof),
        .prof_sel(prof_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
        .out_sof(out_sof), .out_eof(out_eof), .stat_valid(stat_valid),
        .stat_count(stat_count), .stat_prof(stat_prof));

    skin_classifier_stream #(.CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_sof(in_sof), .in_eof(in_eof),
        .prof_sel(prof_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(out_valid2), .out_ready(out_ready), .out_mask(out_mask2),
        .out_sof(out_sof2), .out_eof(out_eof2), .stat_valid(stat_valid2),
        .stat_count(stat_count2), .stat_prof(stat_prof2));

    always #5 clk = ~clk;

    typedef struct { logic [7:0] y, cb, cr; logic sof, eof, mask; } vec_t;
    typedef struct { logic mask, sof, eof; logic [1:0] prof; int stamp; } exp_t;
    typedef struct { logic [19:0] c20; logic [2:0] c3; logic [1:0] prof; int stamp; } st_t;

    exp_t        sbq[$];
    st_t         stq[$];
    int          ncmp = 0, nfail = 0, cyc = 0, nstat = 0, cur_exp = -1;
    logic        strict_lat = 1'b0;
    logic [19:0] last_stat;
    logic [2:0]  last_stat2;
    logic [1:0]  last_prof;
    logic [7:0]  msh [4][6];
    logic [7:0]  mact [6];
    logic [1:0]  mprof;
    logic [19:0] mc20;
    logic [2:0]  mc3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dflt(input int f);
        case (f)
            0: return 8'd80;   1: return 8'd235;
            2: return 8'd85;   3: return 8'd135;
            4: return 8'd135;  default: return 8'd180;
        endcase
    endfunction

    function automatic logic mdl(input logic [7:0] y, cb, cr, input logic [7:0] t[6]);
        return y >= t[0] && y <= t[1] && cb >= t[2] && cb <= t[3] && cr >= t[4] && cr <= t[5];
    endfunction

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk); #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Scoreboard/monitor: everything sampled mid-cycle, ahead of the edge that acts on it.
    always @(negedge clk) begin
        exp_t e;
        st_t  s;
        if (!rst_n) begin
            for (int p = 0; p < 4; p++)
                for (int f = 0; f < 6; f++) msh[p][f] = dflt(f);
            for (int f = 0; f < 6; f++) mact[f] = dflt(f);
            mprof = '0; mc20 = '0; mc3 = '0;
        end else begin
            if (stat_valid || stat_valid2) begin
                if (stq.size() == 0) chk("stat_spurious", {stat_valid, stat_valid2}, 0);
                else begin
                    s = stq.pop_front();
                    nstat++;
                    chk("stat_valid", stat_valid, 1);
                    chk("stat_valid2", stat_valid2, 1);
                    chk("stat_timing", cyc - s.stamp, 1);
                    chk("stat_count", stat_count, s.c20);
                    chk("stat_count_w3", stat_count2, s.c3);
                    chk("stat_prof", stat_prof, s.prof);
                    last_stat = stat_count; last_stat2 = stat_count2; last_prof = stat_prof;
                end
            end
            if (!out_valid) chk("mask_idle", out_mask, 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) chk("out_spurious", out_valid, 0);
                else begin
                    e = sbq.pop_front();
                    chk("out_mask", out_mask, e.mask);
                    chk("out_mask_w3", out_mask2, e.mask);
                    chk("out_sof", out_sof, e.sof);
                    chk("out_eof", out_eof, e.eof);
                    if (strict_lat) chk("latency", cyc - e.stamp, 2);
                    if (e.sof) begin mc20 = {19'd0, e.mask}; mc3 = {2'd0, e.mask}; end
                    else begin
                        if (mc20 != 20'hFFFFF) mc20 = mc20 + {19'd0, e.mask};
                        if (mc3 != 3'h7) mc3 = mc3 + {2'd0, e.mask};
                    end
                    if (e.eof) begin
                        s.c20 = mc20; s.c3 = mc3; s.prof = e.prof; s.stamp = cyc;
                        stq.push_back(s);
                        mc20 = '0; mc3 = '0;
                    end
                end
            end
            if (cfg_we)
                for (int f = 0; f < 6; f++)
                    if (cfg_addr[2:0] == 3'(f)) msh[cfg_addr[4:3]][f] = cfg_wdata;
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    for (int f = 0; f < 6; f++) mact[f] = msh[prof_sel][f];
                    mprof = prof_sel;
                end
                e.mask  = (cur_exp >= 0) ? cur_exp[0] : mdl(in_y, in_cb, in_cr, mact);
                e.sof   = in_sof; e.eof = in_eof; e.prof = mprof; e.stamp = cyc;
                sbq.push_back(e);
            end
        end
    end

    task automatic send(input logic [7:0] y, cb, cr, input logic sof, eof, input int exp);
        logic ok;
        in_valid = 1'b1; in_y = y; in_cb = cb; in_cr = cr; in_sof = sof; in_eof = eof;
        cur_exp = exp;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            if (ok) begin in_valid = 1'b0; return; end
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] p, input logic [2:0] f, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = {p, f}; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sbq.size() == 0 && stq.size() == 0) begin
                repeat (3) @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("drain_timeout", sbq.size() + stq.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, {out_valid, out_valid2}, 0);
        chk({nm, "_mask"}, {out_mask, out_mask2}, 0);
        chk({nm, "_sideband"}, {out_sof, out_eof, out_sof2, out_eof2}, 0);
        chk({nm, "_stat"}, {stat_valid, stat_valid2, stat_prof, stat_prof2}, 0);
        chk({nm, "_count"}, {stat_count, stat_count2}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        int   n0;
        logic [15:0] pat;
        tbl[0] = '{100, 100, 150, 1, 0, 1};
        tbl[1] = '{ 50, 100, 150, 0, 0, 0};
        tbl[2] = '{235, 135, 180, 0, 0, 1};
        tbl[3] = '{236, 135, 180, 0, 0, 0};
        tbl[4] = '{ 80,  85, 135, 0, 0, 1};
        tbl[5] = '{ 79,  85, 135, 0, 0, 0};
        tbl[6] = '{100,  84, 150, 0, 0, 0};
        tbl[7] = '{100, 136, 150, 0, 0, 0};
        tbl[8] = '{100, 100, 134, 0, 0, 0};
        tbl[9] = '{100, 100, 181, 0, 1, 0};

        repeat (3) @(posedge clk); #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Default thresholds, back-to-back, exact 2-cycle latency.
        strict_lat = 1'b1;
        for (int i = 0; i < 10; i++)
            send(tbl[i].y, tbl[i].cb, tbl[i].cr, tbl[i].sof, tbl[i].eof, int'(tbl[i].mask));
        drain();
        chk("table_count", last_stat, 3);
        strict_lat = 1'b0;

        // Backpressure mid-stream: stage registers and outputs must hold.
        fork
            for (int i = 0; i < 12; i++)
                send(8'($urandom_range(60, 250)), 8'($urandom_range(75, 145)),
                     8'($urandom_range(125, 190)), i == 0, i == 11, -1);
            begin
                logic m, s, e;
                repeat (4) @(posedge clk); #1;
                rdy_force = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                    if (k == 0) begin m = out_mask; s = out_sof; e = out_eof; end
                    else chk("bp_hold", {out_mask, out_sof, out_eof}, {m, s, e});
                end
                @(posedge clk); #1;
                rdy_force = 1'b1;
            end
        join
        drain();

        // 16-pixel frame with 7 skin pixels under random downstream ready.
        rand_rdy = 1'b1;
        pat = 16'b1010_0101_0010_0011;
        n0 = nstat;
        for (int i = 0; i < 16; i++)
            if (pat[i]) send(100, 100, 150, i == 0, i == 15, 1);
            else        send(50, 100, 150, i == 0, i == 15, 0);
        drain();
        rand_rdy = 1'b0;
        chk("stats_pulses", nstat - n0, 1);
        chk("stats_count", last_stat, 7);

        // Mid-frame writes wait for the next SOF; a write on the SOF cycle is taken.
        send(100, 100, 150, 1, 0, 1);
        cfg_write(2'd0, 3'd0, 8'd120);
        send(100, 100, 150, 0, 1, 1);
        send(100, 100, 150, 1, 1, 0);
        cfg_we = 1'b1; cfg_addr = {2'd0, 3'd0}; cfg_wdata = 8'd80;
        send(100, 100, 150, 1, 1, 1);
        cfg_we = 1'b0;
        cfg_write(2'd0, 3'd6, 8'd255);
        cfg_write(2'd0, 3'd7, 8'd255);
        send(100, 100, 150, 1, 1, 1);
        drain();

        // Profile 2 opened wide on chroma; prof_sel change mid-frame is ignored.
        cfg_write(2'd2, 3'd2, 8'd0);
        cfg_write(2'd2, 3'd3, 8'd255);
        cfg_write(2'd2, 3'd4, 8'd0);
        cfg_write(2'd2, 3'd5, 8'd255);
        prof_sel = 2'd2;
        send(100, 20, 20, 1, 0, 1);
        prof_sel = 2'd0;
        send(100, 20, 20, 0, 1, 1);
        drain();
        chk("prof_stat_prof", last_prof, 2);
        chk("prof_stat_count", last_stat, 2);

        // Ten skin pixels: full count on CNT_W=20, saturated at 7 on CNT_W=3.
        for (int i = 0; i < 10; i++) send(100, 100, 150, i == 0, i == 9, 1);
        drain();
        chk("sat_count_w20", last_stat, 10);
        chk("sat_count_w3", last_stat2, 7);

        send(100, 100, 150, 1, 1, 1);
        drain();
        chk("one_pixel_count", last_stat, 1);

        // Reset mid-frame: flush, no report, config back to defaults.
        cfg_write(2'd2, 3'd0, 8'd0);
        send(100, 100, 150, 1, 0, 1);
        send(100, 100, 150, 0, 0, 1);
        send(100, 100, 150, 0, 0, 1);
        rst_n = 1'b0;
        sbq.delete(); stq.delete();
        @(posedge clk); #1;
        chk_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        prof_sel = 2'd2;
        send(100, 20, 20, 1, 1, 0);
        prof_sel = 2'd0;
        drain();
        chk("post_reset_prof", last_prof, 2);
        chk("post_reset_count", last_stat, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/skin_classifier_stream.md
Name: skin_classifier_stream

Overview:
- Next-generation YCbCr skin classifier for the gesture pipeline. Sits between the colour-space converter and the mask/centroid logic.
- Adds a valid/ready handshake with backpressure and parametrised channel width.
- Provides N runtime-programmable threshold profiles, committed atomically at start-of-frame.
- Counts skin pixels per frame and reports the total at end-of-frame.

Parameters:
- DATA_W, 8, width of each Y/Cb/Cr channel and of each threshold.
- N_PROF, 4, number of threshold profiles (power of 2, ≥2).
- PROF_W, 2, log2(N_PROF).
- CNT_W, 20, width of the per-frame skin pixel counter.
- Y_MIN/Y_MAX/CB_MIN/CB_MAX/CR_MIN/CR_MAX, 80/235/85/135/135/180, reset value of every profile's thresholds.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts input this cycle.
- in_y, in_cb, in_cr  in  DATA_W each  pixel channels.
- in_sof  in  1  first pixel of frame.
- in_eof  in  1  last pixel of frame.
- prof_sel  in  PROF_W  profile to use, sampled at accepted SOF.
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  PROF_W+3  {profile, field}; field 0..5 = Ymin, Ymax, Cbmin, Cbmax, Crmin, Crmax.
- cfg_wdata  in  DATA_W  threshold value.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_mask  out  1  1 = skin.
- out_sof, out_eof  out  1  delayed sideband.
- stat_valid  out  1  one-cycle pulse, frame count valid.
- stat_count  out  CNT_W  skin pixels in last completed frame.
- stat_prof  out  PROF_W  profile used for that frame.

Behaviour:
- Reset: all outputs 0. All shadow and active thresholds load the parameter defaults. Active profile = 0. Counter = 0.
- Handshake: adv = out_ready | ~out_valid; in_ready = adv (combinational). Both pipeline stages move only when adv. With adv=0, all stage registers and outputs hold.
- Latency: exactly 2 cycles from input acceptance to out_valid when unstalled. Sustained throughput 1 pixel/clk.
- Stage 1 registers six compare bits: y>=min, y<=max, and likewise for Cb and Cr (all unsigned, inclusive). It also registers sof, eof and valid.
- Stage 2: out_mask = AND of the six bits, qualified by valid. out_mask = 0 whenever out_valid = 0.
- Config:
  - cfg_we writes the shadow bank entry at cfg_addr on any cycle, independent of the stream.
  - Field codes 6 and 7 are ignored.
  - The shadow bank copies to the active bank on an accepted SOF (in_valid & in_ready & in_sof). prof_sel is latched on the same cycle.
  - The SOF pixel itself is classified with the new active values and profile.
  - A cfg write in the same cycle as an accepted SOF is included in that copy, i.e. write-through to the copied value.
- Mid-frame cfg writes never affect the current frame.
- Statistics (output side, on handshake out_valid & out_ready):
  - out_sof resets the counter to out_mask.
  - Other pixels add out_mask. The counter saturates at 2^CNT_W-1.
  - On out_eof: stat_count = final total including that pixel; stat_prof = profile of the frame; stat_valid pulses high for 1 cycle on the next clk.
  - A single pixel with both sof and eof set is a 1-pixel frame.
  - EOF with no preceding SOF still reports the running count.
  - A second SOF before EOF restarts the count; no report is made for the aborted frame.
- Reset mid-frame: pipeline is flushed, no stat pulse, config returns to defaults.

Test Plan:
- Defaults: stream (100,100,150), (50,100,150), (235,135,180), (236,135,180) with out_ready=1 → out_mask 1,0,1,0. Each output appears 2 cycles after its input.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream → in_ready=0 and outputs stable throughout. No pixel lost or duplicated (compare against reference model sequence).
- Atomic commit: mid-frame write profile0 Ymin=120, then send (100,100,150) → mask 1. Same pixel as the next frame's SOF → mask 0.
- Profile select: program profile2 Crmin=0, Crmax=255, Cbmin=0, Cbmax=255. Set prof_sel=2 at SOF, send (100,20,20) → mask 1, and stat_prof=2 at EOF.
- Statistics: 16-pixel frame with 7 skin pixels and random out_ready → single stat_valid pulse, stat_count=7.
- Edges:
  - CNT_W=3 with a 10-skin-pixel frame → stat_count=7 (saturation).
  - 1-pixel SOF+EOF skin frame → stat_count=1.
  - rst_n low mid-frame → all outputs 0 next cycle and no stat_valid.
